demux16_rr_scheduler: RTL and testbench



---
 rtl/demux16_rr_scheduler.sv | 164 ++++++++++++++++
 tb/tb_demux16_rr_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/demux16_rr_scheduler.sv
// ---------------------------------------------------------------------------
// demux16_rr_scheduler
//
// Shares one 1:16 demultiplexed data path among 16 requesting sinks.
// In IDLE the scheduler picks one requester, scanning from a rotating pointer,
// and registers its index into sel/gnt. In GRANT it accepts up to HOLD words
// from the source under valid/ready. Each word is routed to the granted sink
// through a registered output stage.
//
// Optional build macro: DEMUX_SCHED_PRIO_EN
//   defined   -> IDLE selection is strict fixed priority (lowest index wins);
//                the rotating pointer does not exist.
//   undefined -> round-robin selection starting at the rotating pointer.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   req_i         in   [15:0] per-sink request
//   din_i         in   [DATA_W-1:0] source data word
//   din_valid_i   in   source word valid
//   din_ready_o   out  scheduler accepts din_i this cycle
//   sel_o         out  [3:0] demux select (index of granted sink)
//   gnt_o         out  [15:0] one-hot grant, zero when idle
//   dout_o        out  [DATA_W-1:0] registered routed word
//   dout_valid_o  out  [15:0] one-hot per-sink strobe for dout_o
//   busy_o        out  high while in GRANT
// ---------------------------------------------------------------------------
module demux16_rr_scheduler #(
    parameter int DATA_W = 8,
    parameter int HOLD   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       req_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic [3:0]        sel_o,
    output logic [15:0]       gnt_o,
    output logic [DATA_W-1:0] dout_o,
    output logic [15:0]       dout_valid_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(HOLD) + 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [15:0]       dv_q, dv_d;

    logic [3:0]        scan_base;
    logic [15:0]       rot_req;
    logic [3:0]        offset;
    logic              found;
    logic [3:0]        pick;
    logic              xfer;
    logic              last;

`ifdef DEMUX_SCHED_PRIO_EN
    assign scan_base = 4'd0;
`else
    logic [3:0] ptr_q, ptr_d;
    assign scan_base = ptr_q;
`endif

    // Rotate the request vector so that bit 0 is the first index to scan.
    // The 4-bit index sum wraps past 15 naturally.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
        assign rot_req[gi] = req_i[scan_base + 4'(gi)];
    end

    // Lowest set bit of the rotated vector; descending loop lets the lowest
    // index overwrite any higher one.
    always_comb begin
        found  = 1'b0;
        offset = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rot_req[i]) begin
                found  = 1'b1;
                offset = 4'(i);
            end
        end
    end

    assign pick = scan_base + offset;
    assign xfer = (state_q == GRANT) && req_i[sel_q] && din_valid_i;
    assign last = (cnt_q == CNT_W'(HOLD - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 4'd0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dv_q    <= '0;
`ifndef DEMUX_SCHED_PRIO_EN
            ptr_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
`ifndef DEMUX_SCHED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dv_d    = '0;         // strobe lasts exactly one cycle after a transfer
`ifndef DEMUX_SCHED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    dout_d = din_i;
                    dv_d   = 16'd1 << sel_q;
                    cnt_d  = cnt_q + 1'b1;
                end
                // A dropped request releases even if din_valid is high:
                // din_ready is already low, so no word is taken.
                if ((xfer && last) || !req_i[sel_q]) begin
                    state_d = IDLE;
`ifndef DEMUX_SCHED_PRIO_EN
                    ptr_d   = sel_q + 4'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: gnt is derived from state/sel so it clears with the state on
    // release and on reset without a separate register.
    always_comb begin
        busy_o       = (state_q == GRANT);
        din_ready_o  = (state_q == GRANT) && req_i[sel_q];
        gnt_o        = (state_q == GRANT) ? (16'd1 << sel_q) : 16'd0;
        sel_o        = sel_q;
        dout_o       = dout_q;
        dout_valid_o = dv_q;
    end

endmodule

// File: tb/tb_demux16_rr_scheduler.sv
// Directed, table-driven bench for demux16_rr_scheduler (DATA_W=8, HOLD=4).
// Each table row holds the inputs applied before a rising edge and the
// outputs expected just after that edge (inputs still applied).
module tb_demux16_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic [7:0]  dout;
    logic [15:0] dout_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux16_rr_scheduler #(.DATA_W(8), .HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .din_ready_o  (din_ready),
        .sel_o        (sel),
        .gnt_o        (gnt),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .busy_o       (busy)
    );

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        vld;
        logic [7:0]  din;
        logic        busy;
        logic [3:0]  sel;
        logic [15:0] gnt;
        logic        rdy;
        logic [7:0]  dout;
        logic [15:0] dv;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [15:0] rq, input logic v,
                                input logic [7:0] d, input logic eb, input logic [3:0] es,
                                input logic [15:0] eg, input logic er, input logic [7:0] ed,
                                input logic [15:0] edv);
        vec_t e;
        e.rst = r; e.req = rq; e.vld = v; e.din = d;
        e.busy = eb; e.sel = es; e.gnt = eg; e.rdy = er; e.dout = ed; e.dv = edv;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Test 2: single requester, bursts of 4 then one idle cycle.
        add(1, 16'h0001, 0, 8'h00, 0, 4'h0, 16'h0000, 0, 8'h00, 16'h0000);
        add(0, 16'h0001, 1, 8'hA1, 1, 4'h0, 16'h0001, 1, 8'h00, 16'h0000);
        add(0, 16'h0001, 1, 8'hA1, 1, 4'h0, 16'h0001, 1, 8'hA1, 16'h0001);
        add(0, 16'h0001, 1, 8'hA2, 1, 4'h0, 16'h0001, 1, 8'hA2, 16'h0001);
        add(0, 16'h0001, 1, 8'hA3, 1, 4'h0, 16'h0001, 1, 8'hA3, 16'h0001);
        add(0, 16'h0001, 1, 8'hA4, 0, 4'h0, 16'h0000, 0, 8'hA4, 16'h0001);
        add(0, 16'h0001, 1, 8'hA5, 1, 4'h0, 16'h0001, 1, 8'hA4, 16'h0000);
        add(0, 16'h0001, 1, 8'hA5, 1, 4'h0, 16'h0001, 1, 8'hA5, 16'h0001);
        add(0, 16'h0001, 1, 8'hA6, 1, 4'h0, 16'h0001, 1, 8'hA6, 16'h0001);
`ifndef DEMUX_SCHED_PRIO_EN
        // Test 3: sinks 0 and 15 alternate, pointer wraps 15 -> 0.
        add(1, 16'h8001, 0, 8'h00, 0, 4'h0, 16'h0000, 0, 8'h00, 16'h0000);
        add(0, 16'h8001, 1, 8'hB0, 1, 4'h0, 16'h0001, 1, 8'h00, 16'h0000);
        add(0, 16'h8001, 1, 8'hB1, 1, 4'h0, 16'h0001, 1, 8'hB1, 16'h0001);
        add(0, 16'h8001, 1, 8'hB2, 1, 4'h0, 16'h0001, 1, 8'hB2, 16'h0001);
        add(0, 16'h8001, 1, 8'hB3, 1, 4'h0, 16'h0001, 1, 8'hB3, 16'h0001);
        add(0, 16'h8001, 1, 8'hB4, 0, 4'h0, 16'h0000, 0, 8'hB4, 16'h0001);
        add(0, 16'h8001, 1, 8'hB5, 1, 4'hF, 16'h8000, 1, 8'hB4, 16'h0000);
        add(0, 16'h8001, 1, 8'hB5, 1, 4'hF, 16'h8000, 1, 8'hB5, 16'h8000);
        add(0, 16'h8001, 1, 8'hB6, 1, 4'hF, 16'h8000, 1, 8'hB6, 16'h8000);
        add(0, 16'h8001, 1, 8'hB7, 1, 4'hF, 16'h8000, 1, 8'hB7, 16'h8000);
        add(0, 16'h8001, 1, 8'hB8, 0, 4'hF, 16'h0000, 0, 8'hB8, 16'h8000);
        add(0, 16'h8001, 1, 8'hB9, 1, 4'h0, 16'h0001, 1, 8'hB8, 16'h0000);
        add(0, 16'h8001, 1, 8'hB9, 1, 4'h0, 16'h0001, 1, 8'hB9, 16'h0001);
        // Test 4: sink 5 drops its request alongside din_valid after 2 words;
        // next grant is 7 (above 5), not 2.
        add(1, 16'h00A0, 0, 8'h00, 0, 4'h0, 16'h0000, 0, 8'h00, 16'h0000);
        add(0, 16'h00A0, 1, 8'hC0, 1, 4'h5, 16'h0020, 1, 8'h00, 16'h0000);
        add(0, 16'h00A4, 1, 8'hC1, 1, 4'h5, 16'h0020, 1, 8'hC1, 16'h0020);
        add(0, 16'h00A4, 1, 8'hC2, 1, 4'h5, 16'h0020, 1, 8'hC2, 16'h0020);
        add(0, 16'h0084, 1, 8'hC3, 0, 4'h5, 16'h0000, 0, 8'hC2, 16'h0000);
        add(0, 16'h0084, 1, 8'hC4, 1, 4'h7, 16'h0080, 1, 8'hC2, 16'h0000);
        add(0, 16'h0084, 1, 8'hC5, 1, 4'h7, 16'h0080, 1, 8'hC5, 16'h0080);
`endif

        // Test 1: reset release with no requests for 10 cycles.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("idle.gnt",  c, 32'(gnt), 32'h0);
            chk("idle.sel",  c, 32'(sel), 32'h0);
            chk("idle.busy", c, 32'(busy), 32'h0);
            chk("idle.rdy",  c, 32'(din_ready), 32'h0);
            chk("idle.dv",   c, 32'(dout_valid), 32'h0);
        end

        // Table-driven vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; req = tbl[i].req; din_valid = tbl[i].vld; din = tbl[i].din;
            @(posedge clk); #1;
            chk("vec.busy", i, 32'(busy), 32'(tbl[i].busy));
            chk("vec.sel",  i, 32'(sel), 32'(tbl[i].sel));
            chk("vec.gnt",  i, 32'(gnt), 32'(tbl[i].gnt));
            chk("vec.rdy",  i, 32'(din_ready), 32'(tbl[i].rdy));
            chk("vec.dout", i, 32'(dout), 32'(tbl[i].dout));
            chk("vec.dv",   i, 32'(dout_valid), 32'(tbl[i].dv));
        end

        // Test 5: asynchronous reset mid-burst at sink 9.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 16'h0200; din_valid = 1'b1; din = 8'hD1;
        @(posedge clk); #1;
        chk("arst.pre_sel", 0, 32'(sel), 32'h9);
        @(negedge clk);
        din = 8'hD2;
        @(posedge clk); #1;
        chk("arst.pre_dv",   0, 32'(dout_valid), 32'h0200);
        chk("arst.pre_dout", 0, 32'(dout), 32'hD2);
        #2 rst = 1'b1;
        #1;
        chk("arst.gnt",  0, 32'(gnt), 32'h0);
        chk("arst.sel",  0, 32'(sel), 32'h0);
        chk("arst.busy", 0, 32'(busy), 32'h0);
        chk("arst.rdy",  0, 32'(din_ready), 32'h0);
        chk("arst.dout", 0, 32'(dout), 32'h0);
        chk("arst.dv",   0, 32'(dout_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0; req = 16'h0600;
        @(posedge clk); #1;
        chk("arst.post_sel", 0, 32'(sel), 32'h9);
        chk("arst.post_gnt", 0, 32'(gnt), 32'h0200);

`ifdef DEMUX_SCHED_PRIO_EN
        // Fixed priority: sink 0 always wins against sink 15.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 16'h8001; din_valid = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            chk("prio.gnt15", c, 32'(gnt[15]), 32'h0);
            if (busy) chk("prio.sel", c, 32'(sel), 32'h0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
